// File: rtl/pong_sound_pkg.sv
// Shared definitions for the pong sound-effect generator: event codes, tone
// constants for the 25.175 MHz pixel clock, and the per-axis direction tracker.
package pong_sound_pkg;

  localparam int DEF_CLK_HZ      = 25_175_000;
  localparam int DEF_PADDLE_HALF = 27_424;
  localparam int DEF_WALL_HALF   = 55_697;
  localparam int DEF_SCORE_HALF  = 25_689;
  localparam int DEF_PADDLE_LEN  = 805_600;
  localparam int DEF_WALL_LEN    = 402_800;
  localparam int DEF_SCORE_LEN   = 6_469_975;

  localparam int HALF_W = 16;
  localparam int LEN_W  = 23;

  // Numeric order doubles as priority order.
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_WALL   = 2'd1,
    EV_PADDLE = 2'd2,
    EV_SCORE  = 2'd3
  } event_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TONE = 1'b1
  } state_t;

  typedef struct packed {
    logic dir;
    logic valid;
  } axis_t;

  typedef struct packed {
    axis_t st;
    logic  rev;
  } axis_step_t;

  // Unit steps track direction; any larger jump is a respawn and forgets it.
  function automatic axis_step_t axis_step(input axis_t st, input logic [9:0] pos,
                                           input logic [9:0] prev, input logic enable);
    axis_step_t       r;
    logic signed [10:0] delta;
    delta = signed'({1'b0, pos}) - signed'({1'b0, prev});
    r.st  = st;
    r.rev = 1'b0;
    if (!enable) begin
      r.st.valid = 1'b0;
    end else if (delta == 11'sd1) begin
      r.rev      = st.valid && !st.dir;
      r.st.dir   = 1'b1;
      r.st.valid = 1'b1;
    end else if (delta == -11'sd1) begin
      r.rev      = st.valid && st.dir;
      r.st.dir   = 1'b0;
      r.st.valid = 1'b1;
    end else if (delta != 11'sd0) begin
      r.st.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_sound_tone_gen.sv
// Square-wave tone generator: half-period and length down-counters with an
// audio toggle; starts high on load and ends low after len cycles.
module tone_gen
  import pong_sound_pkg::*;
(
  input  logic              clk_0,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [HALF_W-1:0] half,
  input  logic [LEN_W-1:0]  len,
  output logic              audio,
  output logic              busy,
  output logic              last
);

  logic [HALF_W-1:0] half_q;
  logic [HALF_W-1:0] half_cnt;
  logic [LEN_W-1:0]  len_cnt;

  assign last = busy && (len_cnt <= LEN_W'(1));

  always_ff @(posedge clk_0) begin
    if (rst || clear) begin
      audio    <= 1'b0;
      busy     <= 1'b0;
      half_q   <= '0;
      half_cnt <= '0;
      len_cnt  <= '0;
    end else if (load) begin
      half_q   <= half;
      half_cnt <= half;
      len_cnt  <= len;
      audio    <= 1'b1;
      busy     <= 1'b1;
    end else if (busy) begin
      if (half_cnt <= HALF_W'(1)) begin
        half_cnt <= half_q;
        audio    <= ~audio;
      end else begin
        half_cnt <= half_cnt - HALF_W'(1);
      end
      // End of tone overrides any toggle landing on the same cycle.
      if (len_cnt <= LEN_W'(1)) begin
        busy     <= 1'b0;
        audio    <= 1'b0;
        half_cnt <= '0;
        len_cnt  <= '0;
      end else begin
        len_cnt <= len_cnt - LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/pong_sound.sv
// Sound-effect generator: classifies paddle hits, wall bounces and scores from
// the game state and plays a fixed tone per event with priority preemption.
//   state   | meaning
//   ST_IDLE | silent, waiting for an event
//   ST_TONE | tone for event_code playing
module pong_sound
  import pong_sound_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int PADDLE_HALF = DEF_PADDLE_HALF,
  parameter int WALL_HALF   = DEF_WALL_HALF,
  parameter int SCORE_HALF  = DEF_SCORE_HALF,
  parameter int PADDLE_LEN  = DEF_PADDLE_LEN,
  parameter int WALL_LEN    = DEF_WALL_LEN,
  parameter int SCORE_LEN   = DEF_SCORE_LEN
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic [9:0] sq_xpos,
  input  logic [9:0] sq_ypos,
  input  logic       sq_shown,
  input  logic [3:0] score_p1,
  input  logic [3:0] score_p2,
  input  logic       game_over,
  input  logic       game_startup,
  output logic       audio,
  output logic       sound_active,
  output logic [1:0] event_code
);

  localparam logic [HALF_W-1:0] P_HALF = HALF_W'(PADDLE_HALF);
  localparam logic [HALF_W-1:0] W_HALF = HALF_W'(WALL_HALF);
  localparam logic [HALF_W-1:0] S_HALF = HALF_W'(SCORE_HALF);
  localparam logic [LEN_W-1:0]  P_LEN  = LEN_W'(PADDLE_LEN);
  localparam logic [LEN_W-1:0]  W_LEN  = LEN_W'(WALL_LEN);
  localparam logic [LEN_W-1:0]  S_LEN  = LEN_W'(SCORE_LEN);

  logic unused_cfg;
  assign unused_cfg = (CLK_HZ > 0);

  logic [9:0] prev_x, prev_y;
  logic [3:0] prev_p1, prev_p2;
  logic       prev_go;
  axis_t      ax_x, ax_y;
  axis_step_t step_x, step_y;
  state_t     state;
  event_t     code_q;
  event_t     ev;
  logic       track_en, score_ev, accept;
  logic [HALF_W-1:0] ld_half;
  logic [LEN_W-1:0]  ld_len;
  logic       tone_busy, tone_last;

  assign track_en = sq_shown && !game_startup;
  assign step_x   = axis_step(ax_x, sq_xpos, prev_x, track_en);
  assign step_y   = axis_step(ax_y, sq_ypos, prev_y, track_en);
  assign score_ev = !game_startup &&
                    ((score_p1 > prev_p1) || (score_p2 > prev_p2) || (game_over && !prev_go));

  always_comb begin
    ev = EV_NONE;
    if (score_ev)         ev = EV_SCORE;
    else if (step_x.rev)  ev = EV_PADDLE;
    else if (step_y.rev)  ev = EV_WALL;
  end

  // Equal or higher priority restarts the tone; lower is dropped.
  assign accept = (ev != EV_NONE) && (ev >= code_q);

  always_comb begin
    ld_half = W_HALF;
    ld_len  = W_LEN;
    case (ev)
      EV_SCORE:  begin ld_half = S_HALF; ld_len = S_LEN; end
      EV_PADDLE: begin ld_half = P_HALF; ld_len = P_LEN; end
      default:   begin ld_half = W_HALF; ld_len = W_LEN; end
    endcase
  end

  tone_gen u_tone (
    .clk_0 (clk_0),
    .rst   (rst),
    .load  (accept),
    .clear (game_startup),
    .half  (ld_half),
    .len   (ld_len),
    .audio (audio),
    .busy  (tone_busy),
    .last  (tone_last)
  );

  always_ff @(posedge clk_0) begin
    if (rst) begin
      prev_x       <= sq_xpos;
      prev_y       <= sq_ypos;
      prev_p1      <= score_p1;
      prev_p2      <= score_p2;
      prev_go      <= game_over;
      ax_x         <= '0;
      ax_y         <= '0;
      state        <= ST_IDLE;
      code_q       <= EV_NONE;
      sound_active <= 1'b0;
    end else begin
      prev_x  <= sq_xpos;
      prev_y  <= sq_ypos;
      prev_p1 <= score_p1;
      prev_p2 <= score_p2;
      prev_go <= game_over;
      ax_x    <= step_x.st;
      ax_y    <= step_y.st;
      if (game_startup) begin
        state        <= ST_IDLE;
        code_q       <= EV_NONE;
        sound_active <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state        <= ST_TONE;
              code_q       <= ev;
              sound_active <= 1'b1;
            end
          end
          ST_TONE: begin
            if (accept) begin
              code_q <= ev;
            end else if (tone_last || !tone_busy) begin
              state        <= ST_IDLE;
              code_q       <= EV_NONE;
              sound_active <= 1'b0;
            end
          end
          default: begin
            state        <= ST_IDLE;
            code_q       <= EV_NONE;
            sound_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign event_code = code_q;

endmodule

// File: tb/tb_pong_sound.sv
// Scoreboard bench for pong_sound with shortened tone constants; each driven
// cycle queues the expected {event_code, sound_active, audio} for that edge.
module tb_pong_sound;

  localparam int P_H = 5;
  localparam int P_L = 40;
  localparam int W_H = 7;
  localparam int W_L = 30;
  localparam int S_H = 4;
  localparam int S_L = 60;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic [9:0] sq_xpos, sq_ypos;
  logic       sq_shown;
  logic [3:0] score_p1, score_p2;
  logic       game_over, game_startup;
  logic       audio, sound_active;
  logic [1:0] event_code;

  typedef struct {
    string      tag;
    logic [3:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  pong_sound #(
    .PADDLE_HALF (P_H),
    .WALL_HALF   (W_H),
    .SCORE_HALF  (S_H),
    .PADDLE_LEN  (P_L),
    .WALL_LEN    (W_L),
    .SCORE_LEN   (S_L)
  ) dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .sq_xpos      (sq_xpos),
    .sq_ypos      (sq_ypos),
    .sq_shown     (sq_shown),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .game_over    (game_over),
    .game_startup (game_startup),
    .audio        (audio),
    .sound_active (sound_active),
    .event_code   (event_code)
  );

  always #5 clk_0 = ~clk_0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (code,active,audio) t=%0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clk_0) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, {4'h0, event_code, sound_active, audio}, {4'h0, e.val});
    end
  end

  // Inputs are already set; queue what the next edge must produce, then move past it.
  task automatic tick(input logic [1:0] code, input logic act, input logic aud, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = {code, act, aud};
    q.push_back(e);
    @(negedge clk_0);
    #1;
  endtask

  task automatic play(input logic [1:0] code, input int half, input int len, input string tag);
    for (int i = 0; i < len; i++) tick(code, 1'b1, ((i / half) % 2) == 0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sq_xpos = 10'd300; sq_ypos = 10'd20; sq_shown = 1'b1;
    score_p1 = 4'd3; score_p2 = 4'd0; game_over = 1'b0; game_startup = 1'b0;
    @(negedge clk_0); #1;
    tick(2'd0, 1'b0, 1'b0, "reset");
    tick(2'd0, 1'b0, 1'b0, "reset");
    rst = 1'b0;
    tick(2'd0, 1'b0, 1'b0, "post_reset_idle");
    tick(2'd0, 1'b0, 1'b0, "post_reset_idle");

    // paddle hit: 300 -> 301 -> 302 -> 301
    sq_xpos = 10'd301; tick(2'd0, 1'b0, 1'b0, "px_step");
    sq_xpos = 10'd302; tick(2'd0, 1'b0, 1'b0, "px_step");
    sq_xpos = 10'd301; play(2'd2, P_H, P_L, "paddle_tone");
    tick(2'd0, 1'b0, 1'b0, "paddle_end");

    // wall bounce then paddle preemption without a gap
    sq_ypos = 10'd19; tick(2'd0, 1'b0, 1'b0, "wy_step");
    sq_ypos = 10'd18; tick(2'd0, 1'b0, 1'b0, "wy_step");
    sq_ypos = 10'd19;
    for (int i = 0; i < 10; i++) tick(2'd1, 1'b1, ((i / W_H) % 2) == 0, "wall_tone");
    sq_xpos = 10'd302; play(2'd2, P_H, P_L, "preempt_paddle");
    tick(2'd0, 1'b0, 1'b0, "preempt_end");

    // score together with x reversal; later wall reversal must be ignored
    sq_xpos = 10'd301; score_p1 = 4'd4;
    for (int i = 0; i < S_L; i++) begin
      if (i == 10) sq_ypos = 10'd18;
      tick(2'd3, 1'b1, ((i / S_H) % 2) == 0, "score_tone");
    end
    tick(2'd0, 1'b0, 1'b0, "score_end");

    // respawn jump: no event
    sq_xpos = 10'd620; tick(2'd0, 1'b0, 1'b0, "respawn");
    sq_xpos = 10'd320; tick(2'd0, 1'b0, 1'b0, "respawn");
    sq_xpos = 10'd319; tick(2'd0, 1'b0, 1'b0, "respawn_step");

    // game over with scores cleared
    game_over = 1'b1; score_p1 = 4'd0; score_p2 = 4'd0;
    play(2'd3, S_H, S_L, "game_over_tone");
    tick(2'd0, 1'b0, 1'b0, "game_over_end");
    game_over = 1'b0; tick(2'd0, 1'b0, 1'b0, "game_over_fall");
    score_p2 = 4'd10; play(2'd3, S_H, S_L, "p2_score_tone");
    tick(2'd0, 1'b0, 1'b0, "p2_score_end");
    score_p2 = 4'd0; tick(2'd0, 1'b0, 1'b0, "score_drop");

    // muted during startup menu
    game_startup = 1'b1;
    sq_xpos = 10'd320; tick(2'd0, 1'b0, 1'b0, "mute");
    sq_xpos = 10'd319; tick(2'd0, 1'b0, 1'b0, "mute");
    sq_xpos = 10'd320; tick(2'd0, 1'b0, 1'b0, "mute");
    sq_ypos = 10'd19;  tick(2'd0, 1'b0, 1'b0, "mute");
    score_p1 = 4'd2;   tick(2'd0, 1'b0, 1'b0, "mute_score");
    game_startup = 1'b0; tick(2'd0, 1'b0, 1'b0, "unmute");

    // reset mid score tone
    score_p1 = 4'd3;
    for (int i = 0; i < 10; i++) tick(2'd3, 1'b1, ((i / S_H) % 2) == 0, "pre_rst_tone");
    rst = 1'b1;
    tick(2'd0, 1'b0, 1'b0, "rst_mid_tone");
    score_p1 = 4'd5; sq_xpos = 10'd100;
    tick(2'd0, 1'b0, 1'b0, "rst_hold");
    rst = 1'b0;
    tick(2'd0, 1'b0, 1'b0, "rst_release");
    tick(2'd0, 1'b0, 1'b0, "rst_release");
    tick(2'd0, 1'b0, 1'b0, "rst_release");

    chk("queue_drain", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_sound.md
# pong_sound

Sound-effect generator downstream of the game logic. It watches the square's position, the scores and the game-state flags, and classifies what happens into three events: paddle hit, wall bounce and point scored. For each event it drives a 1-bit square-wave tone of fixed pitch and duration to the board's piezo/audio pin. It runs on the 25.175 MHz pixel clock alongside the game logic and needs no handshake with it.

## Interface
Parameters:
- CLK_HZ, 25_175_000, clock frequency; informational, all counts below are precomputed for it
- PADDLE_HALF, 27_424, half-period in cycles of the paddle tone (459 Hz)
- WALL_HALF, 55_697, half-period in cycles of the wall tone (226 Hz)
- SCORE_HALF, 25_689, half-period in cycles of the score tone (490 Hz)
- PADDLE_LEN, 805_600, paddle tone duration in cycles (32 ms)
- WALL_LEN, 402_800, wall tone duration in cycles (16 ms)
- SCORE_LEN, 6_469_975, score tone duration in cycles (257 ms)

Ports:
- clk_0  in  1  system clock, 25.175 MHz
- rst  in  1  synchronous reset, active-high
- sq_xpos  in  10  square x position from game logic
- sq_ypos  in  10  square y position from game logic
- sq_shown  in  1  square visible/moving
- score_p1  in  4  player 1 score
- score_p2  in  4  player 2 score
- game_over  in  1  game-over flag
- game_startup  in  1  startup-menu flag
- audio  out  1  square-wave tone output
- sound_active  out  1  high while a tone is playing
- event_code  out  2  tone currently playing: 0 none, 1 wall, 2 paddle, 3 score

## Operation
- **Input history.** Register previous copies of sq_xpos, sq_ypos, score_p1, score_p2 and game_over every cycle.
- **Per-axis direction tracker.** Each axis holds a dir bit and a valid bit. Compute delta = current − previous, as an 11-bit signed value.
  - delta = +1: if valid and dir==0, flag a reversal. Then set dir=1, valid=1.
  - delta = −1: if valid and dir==1, flag a reversal. Then set dir=0, valid=1.
  - delta = 0: no change.
  - |delta| > 1 (respawn jump): clear valid and flag nothing.
  - sq_shown==0 clears valid on both axes.
- **Event classification.**
  - PADDLE = x reversal.
  - WALL = y reversal.
  - SCORE = score_p1 or score_p2 greater than its previous value, or a rising edge of game_over.
  - A score dropping to 0 never generates an event.
- **Priority.** SCORE (3) > PADDLE (2) > WALL (1).
  - Simultaneous events: only the highest is taken.
  - An event with priority ≥ the playing tone preempts it and restarts both counters.
  - A lower-priority event is dropped, not queued.
- **State machine.** Two states, IDLE and TONE.
  - IDLE: on an accepted event, load the half-period and length constants for that event, set event_code, and go to TONE.
  - TONE: decrement the half-period counter. At 1, reload it and toggle audio.
  - TONE: decrement the length counter. At 1, return to IDLE with audio=0 and event_code=0.
- **Mute.** While game_startup==1, force IDLE and clear both trackers' valid bits. Events are ignored.
- **Counter widths.** Half-period counter 16 bits, length counter 23 bits. Counters never wrap.

## Timing
- **Reset.** audio=0, sound_active=0, event_code=0, state IDLE, trackers invalid. All history registers take the current input values, so no event fires on the first cycle after reset.
- **Reset mid-tone** stops the tone on the next edge.
- **Latency.** An input change present before edge k gives audio=1, sound_active=1 and event_code valid after edge k (1 cycle).
- **Tone length.** sound_active stays high for exactly LEN cycles. audio toggles every HALF cycles, starting high.
- sound_active == (state==TONE). event_code is nonzero iff sound_active.
- **Preemption** restarts the tone in the same edge, with audio=1. There is no idle gap.

## Structure
- Shared package/include pong_defs:
  - event code constants EV_NONE/EV_WALL/EV_PADDLE/EV_SCORE
  - the six tone constants
  - 25.175 MHz CLK_HZ
- Sub-module tone_gen holds the half-period and length counters and the audio toggle. Its interface is load strobe, half, len in; audio, busy out.
- The direction trackers are two instances of one small always block or function. They are not a separate module.

## Test plan
- **Paddle hit.** Step x 300→301→302→301 with sq_shown=1 → event_code=2 after the 301 edge. audio toggles every 27_424 cycles, and sound_active falls after 805_600 cycles.
- **Wall bounce.** Step y 20→19→18→19 → event_code=1, 402_800-cycle tone. Then a paddle reversal 1000 cycles later → preempts to event_code=2 with no idle cycle.
- **Score vs lower events.** score_p1 3→4 in the same cycle as an x reversal → event_code=3 only. A wall reversal during the score tone → ignored, and event_code stays 3.
- **Respawn and game over.** x jump 620→320, then steps 320→319 → no event. game_over 0→1 with scores reset to 0 → score tone. Scores alone 10→0 → no event.
- **Mute.** game_startup=1 while reversals are driven → audio=0 and sound_active=0 throughout.
- **Reset.** rst asserted mid-score-tone → all outputs 0 after the next edge. No event on the first cycle after release with inputs static.
